// File: rtl/fifo_burst_reader_if.sv
// Output stream of fifo_burst_reader: data with sof/eof framing.
// Handshake: a word moves when m_valid && m_ready at a rising edge; once m_valid is
// raised, m_data/m_sof/m_eof stay stable until that transfer happens.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_sof;
    logic                  m_eof;

    modport master (
        output m_data,
        output m_valid,
        output m_sof,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_sof,
        input  m_eof,
        output m_ready
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains fixed-length (or flush-length) bursts from a counter-based sync FIFO
// and replays them on a framed valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int BURST_LEN  = 4,
    localparam int CW        = $clog2(DATA_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CW-1:0]         fifo_cnt,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    fifo_burst_reader_if.master   m_if,
    output logic                  busy,
    output logic [15:0]           burst_cnt,
    output logic [1:0]            dbg_state
);

    if (BURST_LEN < 1 || BURST_LEN > DATA_DEPTH) begin : g_bad_burst_len
        $error("fifo_burst_reader: BURST_LEN must be in 1..DATA_DEPTH");
    end

    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
    localparam logic [CW-1:0] ONE_C       = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         rd_left_q, rd_left_d;
    logic [CW-1:0]         out_left_q, out_left_d;
    logic                  pend_q, pend_d;
    logic [15:0]           burst_cnt_q, burst_cnt_d;

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            occ_q;

    logic                  push;
    logic                  pop;
    logic                  rd_en;
    logic                  eof_xfer;
    logic [2:0]            room_need;

    // Stream side is driven straight from the buffer head; framing comes from
    // out_left, which only moves on a transfer, so sof/eof are stable under stall.
    assign push          = pend_q;
    assign m_if.m_valid  = (occ_q != 2'd0);
    assign m_if.m_data   = buf_q[rd_ptr_q];
    assign m_if.m_sof    = m_if.m_valid && (out_left_q == len_q);
    assign m_if.m_eof    = m_if.m_valid && (out_left_q == ONE_C);
    assign pop           = m_if.m_valid && m_if.m_ready;
    assign eof_xfer      = pop && m_if.m_eof && (state_q == DRAIN);

    // Slots the buffer will hold after this edge if no new read is issued.
    assign room_need = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};

    assign fifo_rd_en = rd_en;
    assign busy       = (state_q != IDLE);
    assign burst_cnt  = burst_cnt_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rd_left_d   = rd_left_q;
        out_left_d  = out_left_q;
        pend_d      = 1'b0;
        rd_en       = 1'b0;
        burst_cnt_d = burst_cnt_q;

        if (pop) begin
            out_left_d = out_left_q - ONE_C;
        end

        case (state_q)
            IDLE: begin
                if (fifo_cnt >= BURST_LEN_C) begin
                    len_d      = BURST_LEN_C;
                    rd_left_d  = BURST_LEN_C;
                    out_left_d = BURST_LEN_C;
                    state_d    = READ;
                end else if (flush && (fifo_cnt != '0)) begin
                    len_d      = fifo_cnt;
                    rd_left_d  = fifo_cnt;
                    out_left_d = fifo_cnt;
                    state_d    = READ;
                end
            end
            READ: begin
                rd_en = !rst && (rd_left_q != '0) && !fifo_empty && (room_need < 3'd2);
                if (rd_en) begin
                    rd_left_d = rd_left_q - ONE_C;
                    pend_d    = 1'b1;
                    if (rd_left_q == ONE_C) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (eof_xfer) begin
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            rd_left_q   <= '0;
            out_left_q  <= '0;
            pend_q      <= 1'b0;
            burst_cnt_q <= 16'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_left_q   <= rd_left_d;
            out_left_q  <= out_left_d;
            pend_q      <= pend_d;
            burst_cnt_q <= burst_cnt_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Buffer storage needs no reset: occupancy gates every use of it.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_q[wr_ptr_q] <= fifo_data;
        end
    end

endmodule
